// File: rtl/com_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : com_adc_pkg
// Purpose  : Shared widths, the capture FSM state encoding and the trigger
//            mark bit position for the communications ADC capture front end.
// Revision : 1.0  initial release
// ============================================================================
package com_adc_pkg;

  localparam int ADC_W    = 10;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int MARK_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/com_adc_wrptr.sv
`default_nettype none
// ============================================================================
// Module   : com_adc_wrptr
// Purpose  : Circular write pointer for the sample memory. Clear wins over
//            increment; the pointer wraps from DEPTH-1 back to 0.
// Revision : 1.0  initial release
// ============================================================================
module com_adc_wrptr #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_q;

  // Next pointer: clear to the ring origin, or step with wrap at the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/com_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : com_adc_capture
// Purpose  : ADC acquisition front end. Writes samples circularly into the
//            512x16 sample memory, keeps a programmable pre-trigger history,
//            marks the trigger sample and stops after a full ring around it.
//            Reports the oldest-sample and trigger addresses for readout.
// Revision : 1.0  initial release
// ============================================================================
module com_adc_capture
  import com_adc_pkg::*;
#(
  parameter int ADC_W  = com_adc_pkg::ADC_W,
  parameter int ADDR_W = com_adc_pkg::ADDR_W,
  parameter int DATA_W = com_adc_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [ADDR_W-1:0] pre_len,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int                DEPTH_L = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH_L - 1);
  localparam logic [ADDR_W-1:0] C_ONE   = ADDR_W'(1);

  state_t            state_d,      state_q;
  logic [ADDR_W-1:0] pre_d,        pre_q;
  logic [ADDR_W-1:0] cnt_d,        cnt_q;
  logic [ADDR_W-1:0] post_d,       post_q;
  logic [ADDR_W-1:0] trig_addr_d,  trig_addr_q;
  logic [ADDR_W-1:0] start_addr_d, start_addr_q;
  logic [ADDR_W-1:0] wraddress_d,  wraddress_q;
  logic [DATA_W-1:0] data_d,       data_q;
  logic              trig_pend_d,  trig_pend_q;
  logic              done_d,       done_q;
  logic              busy_d,       busy_q;
  logic              wren_d,       wren_q;

  logic              write;
  logic              mark;
  logic              ptr_clr;
  logic              ptr_inc;
  logic [ADDR_W-1:0] ptr;

  com_adc_wrptr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH_L)
  ) u_wrptr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (ptr_clr),
    .i_inc   (ptr_inc),
    .o_ptr   (ptr)
  );

  // Capture control: abort beats arm, arm beats all per-state sample handling.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    cnt_d        = cnt_q;
    post_d       = post_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    trig_pend_d  = trig_pend_q;
    done_d       = done_q;
    wraddress_d  = wraddress_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    write        = 1'b0;
    mark         = 1'b0;
    ptr_clr      = 1'b0;
    ptr_inc      = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      trig_pend_d = 1'b0;
    end else if (arm) begin
      ptr_clr     = 1'b1;
      pre_d       = pre_len;
      cnt_d       = '0;
      done_d      = 1'b0;
      trig_pend_d = 1'b0;
      state_d     = (pre_len == '0) ? ST_ARMED : ST_PRE;
    end else begin
      case (state_q)
        ST_PRE: begin
          if (adc_valid) begin
            write = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == pre_q) begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (trig) begin
            trig_pend_d = 1'b1;
          end
          if (adc_valid) begin
            write = 1'b1;
            if (trig_pend_q || trig) begin
              mark        = 1'b1;
              trig_pend_d = 1'b0;
              trig_addr_d = ptr;
              post_d      = C_LAST - pre_q;
              if (pre_q == C_LAST) begin
                // No post-trigger samples: the trigger write closes the ring.
                state_d      = ST_DONE;
                done_d       = 1'b1;
                start_addr_d = ptr - pre_q;
              end else begin
                state_d = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (adc_valid) begin
            write  = 1'b1;
            post_d = post_q - 1'b1;
            if (post_q == C_ONE) begin
              state_d      = ST_DONE;
              done_d       = 1'b1;
              start_addr_d = trig_addr_q - pre_q;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (write) begin
      ptr_inc             = 1'b1;
      wren_d              = 1'b1;
      wraddress_d         = ptr;
      data_d              = '0;
      data_d[ADC_W-1:0]   = adc_data;
      data_d[MARK_BIT]    = mark;
    end

    busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
  end

  // State and registered outputs; reset drops wren immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      cnt_q        <= '0;
      post_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      trig_pend_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      wren_q       <= 1'b0;
      wraddress_q  <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      post_q       <= post_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      trig_pend_q  <= trig_pend_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      wren_q       <= wren_d;
      wraddress_q  <= wraddress_d;
      data_q       <= data_d;
    end
  end

  assign data       = data_q;
  assign wraddress  = wraddress_q;
  assign wren       = wren_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign start_addr = start_addr_q;
  assign trig_addr  = trig_addr_q;

endmodule
`default_nettype wire
